// File: rtl/iobus_ctrl.sv
// CPU bus bridge: decodes each access to either a synchronous RAM port or a
// small I/O block (GPIO, display register, free-running counter).
module iobus_ctrl #(
    parameter int unsigned MEM_AW = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic [7:0]        sw,
    input  logic [3:0]        btn,
    output logic [7:0]        led,
    output logic [31:0]       disp_data
);

    typedef enum logic [1:0] {IDLE, MEM_ISSUE, MEM_WAIT, DONE} state_t;

    state_t      state;
    state_t      next_state;
    logic        sel_io;
    logic        accept;
    logic        io_wr;
    logic        io_rd;
    logic        ram_acc;
    logic        ram_cap;
    logic        ready_d;
    logic        mem_en_d;
    logic        mem_we_d;
    logic [31:0] io_rdata;
    logic [31:0] cnt;
    logic        unused_addr;

    // Only the decode, register-select and RAM word-address bits matter.
    assign unused_addr = ^cpu_addr;
    assign sel_io      = (cpu_addr[31:28] == 4'hF);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (cpu_req) next_state = sel_io ? DONE : MEM_ISSUE;
            MEM_ISSUE: next_state = mem_we ? DONE : MEM_WAIT;
            MEM_WAIT:  next_state = DONE;
            DONE:      next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    // Request inputs are consumed only on the accepting edge; from then on the
    // access runs from registered copies (mem_* outputs and the FSM state).
    always_comb begin
        accept   = 1'b0;
        io_wr    = 1'b0;
        io_rd    = 1'b0;
        ram_acc  = 1'b0;
        ram_cap  = 1'b0;
        ready_d  = 1'b0;
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
        accept   = (state == IDLE) && cpu_req;
        io_wr    = accept && sel_io && cpu_we;
        io_rd    = accept && sel_io && !cpu_we;
        ram_acc  = accept && !sel_io;
        ram_cap  = (state == MEM_WAIT);
        ready_d  = (next_state == DONE);
        mem_en_d = (next_state == MEM_ISSUE);
        mem_we_d = mem_en_d && cpu_we;
    end

    always_comb begin
        io_rdata = 32'd0;
        case (cpu_addr[3:2])
            2'b00:   io_rdata = {20'd0, btn, sw};
            2'b01:   io_rdata = disp_data;
            2'b10:   io_rdata = cnt;
            default: io_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_ready <= 1'b0;
            cpu_rdata <= 32'd0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'd0;
            led       <= 8'd0;
            disp_data <= 32'd0;
            cnt       <= 32'd0;
        end else begin
            cpu_ready <= ready_d;
            mem_en    <= mem_en_d;
            mem_we    <= mem_we_d;
            if (ram_acc) begin
                mem_addr  <= cpu_addr[MEM_AW+1:2];
                mem_wdata <= cpu_wdata;
            end
            if (io_rd)        cpu_rdata <= io_rdata;
            else if (ram_cap) cpu_rdata <= mem_rdata;
            if (io_wr && cpu_addr[3:2] == 2'b00) led       <= cpu_wdata[7:0];
            if (io_wr && cpu_addr[3:2] == 2'b01) disp_data <= cpu_wdata;
            // A counter write takes priority over the free-running increment.
            if (io_wr && cpu_addr[3:2] == 2'b10) cnt <= cpu_wdata;
            else                                 cnt <= cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_iobus_ctrl.sv
// Directed bench for iobus_ctrl: I/O map, RAM timing, counter wrap, reset abort
// and request latching, with a behavioural synchronous RAM model.
module tb_iobus_ctrl;

    localparam int unsigned MEM_AW = 10;

    logic              clk;
    logic              rst;
    logic              cpu_req;
    logic              cpu_we;
    logic [31:0]       cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [31:0]       cpu_rdata;
    logic              cpu_ready;
    logic              mem_en;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic [7:0]        sw;
    logic [3:0]        btn;
    logic [7:0]        led;
    logic [31:0]       disp_data;

    int errors = 0;
    int checks = 0;

    logic [31:0] ram [0:(1<<MEM_AW)-1];

    iobus_ctrl #(.MEM_AW(MEM_AW)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .sw(sw), .btn(btn), .led(led), .disp_data(disp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM: read data valid the cycle after mem_en.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one access from IDLE; scrambles the request inputs right after the
    // accepting edge. lat = number of edges from accept until ready is seen.
    task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             output int lat, output int en_cnt,
                             output logic [MEM_AW-1:0] en_addr, output logic en_we,
                             output logic ready_low);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        tick();
        cpu_req = 1'b0; cpu_we = ~we; cpu_addr = 32'h0000_0FF0; cpu_wdata = 32'hBAD0_BAD0;
        lat = 0; en_cnt = 0; en_addr = '0; en_we = 1'b0;
        for (int i = 1; i <= 8 && lat == 0; i++) begin
            if (mem_en) begin
                en_cnt++;
                en_addr = mem_addr;
                en_we   = mem_we;
            end
            if (cpu_ready) lat = i;
            else           tick();
        end
        tick();
        ready_low = !cpu_ready;
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
        sw = 8'h00; btn = 4'h0;
        #3;
        checks++;
        if ({cpu_ready, mem_en, mem_we} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 000", {cpu_ready, mem_en, mem_we});
        end
        checks++;
        if (cpu_rdata !== 32'd0 || mem_addr !== '0 || mem_wdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_data: rdata=%h addr=%h wdata=%h expected zeros", cpu_rdata, mem_addr, mem_wdata);
        end
        checks++;
        if (led !== 8'd0 || disp_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_regs: led=%h disp=%h expected zeros", led, disp_data);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_gpio();
        int lat, en; logic [MEM_AW-1:0] ea; logic ew, rl;
        do_access(1'b1, 32'hF000_0000, 32'h0000_00A5, lat, en, ea, ew, rl);
        check32("gpio_wr_led", {24'd0, led}, 32'h0000_00A5);
        check32("gpio_wr_lat", 32'(lat), 32'd1);
        check32("gpio_wr_memen", 32'(en), 32'd0);
        check32("gpio_wr_ready_pulse", {31'd0, rl}, 32'd1);
        check32("gpio_wr_rdata_hold", cpu_rdata, 32'd0);
        sw = 8'h3C; btn = 4'h5;
        do_access(1'b0, 32'hF000_0000, 32'd0, lat, en, ea, ew, rl);
        check32("gpio_rd_data", cpu_rdata, 32'h0000_053C);
        check32("gpio_rd_lat", 32'(lat), 32'd1);
    endtask

    task automatic test_display_reserved();
        int lat, en; logic [MEM_AW-1:0] ea; logic ew, rl;
        do_access(1'b1, 32'hF000_0004, 32'h1234_5678, lat, en, ea, ew, rl);
        check32("disp_wr", disp_data, 32'h1234_5678);
        check32("disp_wr_rdata_hold", cpu_rdata, 32'h0000_053C);
        do_access(1'b0, 32'hF000_0004, 32'd0, lat, en, ea, ew, rl);
        check32("disp_rd", cpu_rdata, 32'h1234_5678);
        do_access(1'b1, 32'hF000_000C, 32'hFFFF_FFFF, lat, en, ea, ew, rl);
        check32("rsvd_wr_led", {24'd0, led}, 32'h0000_00A5);
        check32("rsvd_wr_disp", disp_data, 32'h1234_5678);
        do_access(1'b0, 32'hF000_000C, 32'd0, lat, en, ea, ew, rl);
        check32("rsvd_rd", cpu_rdata, 32'd0);
    endtask

    task automatic test_ram();
        int lat, en; logic [MEM_AW-1:0] ea; logic ew, rl;
        do_access(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, lat, en, ea, ew, rl);
        check32("ram_wr_lat", 32'(lat), 32'd2);
        check32("ram_wr_en_pulses", 32'(en), 32'd1);
        check32("ram_wr_addr", 32'(ea), 32'd4);
        check32("ram_wr_we", {31'd0, ew}, 32'd1);
        check32("ram_wr_rdata_hold", cpu_rdata, 32'd0);
        do_access(1'b0, 32'h0000_0010, 32'd0, lat, en, ea, ew, rl);
        check32("ram_rd_data", cpu_rdata, 32'hDEAD_BEEF);
        check32("ram_rd_lat", 32'(lat), 32'd3);
        check32("ram_rd_en_pulses", 32'(en), 32'd1);
        check32("ram_rd_addr", 32'(ea), 32'd4);
        check32("ram_rd_we", {31'd0, ew}, 32'd0);
        check32("ram_rd_ready_pulse", {31'd0, rl}, 32'd1);
        check32("ram_idle_memen", {31'd0, mem_en | mem_we}, 32'd0);
    endtask

    task automatic test_counter();
        int lat, en; logic [MEM_AW-1:0] ea; logic ew, rl;
        // Write lands at E0 (FFFFFFFE); reads accepted at E2 and E4 see
        // FFFFFFFF then 1 after wrapping through 0.
        do_access(1'b1, 32'hF000_0008, 32'hFFFF_FFFE, lat, en, ea, ew, rl);
        do_access(1'b0, 32'hF000_0008, 32'd0, lat, en, ea, ew, rl);
        check32("cnt_rd_before_wrap", cpu_rdata, 32'hFFFF_FFFF);
        do_access(1'b0, 32'hF000_0008, 32'd0, lat, en, ea, ew, rl);
        check32("cnt_rd_after_wrap", cpu_rdata, 32'h0000_0001);
    endtask

    task automatic test_abort();
        int lat, en; logic [MEM_AW-1:0] ea; logic ew, rl;
        int seen_ready;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0010; cpu_wdata = 32'h5A5A_5A5A;
        tick();
        cpu_req = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({cpu_ready, mem_en, mem_we} !== 3'b000 || cpu_rdata !== 32'd0 || mem_addr !== '0 ||
            mem_wdata !== 32'd0 || led !== 8'd0 || disp_data !== 32'd0) begin
            errors++;
            $display("FAIL abort_outputs: ready=%b en=%b we=%b rdata=%h addr=%h wdata=%h led=%h disp=%h expected zeros",
                     cpu_ready, mem_en, mem_we, cpu_rdata, mem_addr, mem_wdata, led, disp_data);
        end
        #2 rst = 1'b0;
        seen_ready = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (cpu_ready) seen_ready++;
        end
        check32("abort_no_ready", 32'(seen_ready), 32'd0);
        check32("abort_rdata_still_zero", cpu_rdata, 32'd0);
        sw = 8'h81; btn = 4'hA;
        do_access(1'b0, 32'hF000_0000, 32'd0, lat, en, ea, ew, rl);
        check32("abort_next_rd", cpu_rdata, 32'h0000_0A81);
        check32("abort_next_lat", 32'(lat), 32'd1);
    endtask

    task automatic test_back_to_back();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'hF000_0004; cpu_wdata = 32'h1111_1111;
        tick();
        cpu_addr = 32'hF000_0000; cpu_wdata = 32'h0000_00FF;
        check32("b2b_first_ready", {31'd0, cpu_ready}, 32'd1);
        check32("b2b_first_disp", disp_data, 32'h1111_1111);
        check32("b2b_first_led", {24'd0, led}, 32'd0);
        tick();
        check32("b2b_gap_ready", {31'd0, cpu_ready}, 32'd0);
        check32("b2b_gap_led", {24'd0, led}, 32'd0);
        tick();
        cpu_req = 1'b0;
        check32("b2b_second_ready", {31'd0, cpu_ready}, 32'd1);
        check32("b2b_second_led", {24'd0, led}, 32'h0000_00FF);
        check32("b2b_second_disp", disp_data, 32'h1111_1111);
        tick();
        check32("b2b_end_ready", {31'd0, cpu_ready}, 32'd0);
    endtask

    initial begin
        mem_rdata = 32'd0;
        test_reset();
        test_gpio();
        test_display_reserved();
        test_ram();
        test_counter();
        test_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/iobus_ctrl.md
IOBUS_CTRL -- requirements
Module: iobus_ctrl

Interface
REQ-001 Parameter MEM_AW, default 10, SHALL set the RAM word-address width.
REQ-002 clk  in  1  system clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-high.
REQ-004 cpu_req  in  1  CPU bus access request, level.
REQ-005 cpu_we  in  1  1 = write, 0 = read.
REQ-006 cpu_addr  in  32  byte address.
REQ-007 cpu_wdata  in  32  write data.
REQ-008 cpu_rdata  out  32  read data, registered.
REQ-009 cpu_ready  out  1  one-cycle access-complete pulse.
REQ-010 mem_en  out  1  RAM enable.
REQ-011 mem_we  out  1  RAM write enable.
REQ-012 mem_addr  out  MEM_AW  RAM word address.
REQ-013 mem_wdata  out  32  RAM write data.
REQ-014 mem_rdata  in  32  RAM read data, valid one cycle after mem_en.
REQ-015 sw  in  8  switch inputs.
REQ-016 btn  in  4  button inputs.
REQ-017 led  out  8  LED register.
REQ-018 disp_data  out  32  seven-segment display data register.

Function
REQ-019 Decode: cpu_addr[31:28]==4'hF SHALL select I/O; all other addresses SHALL select RAM.
REQ-020 I/O map by cpu_addr[3:2]: 00 GPIO (read {20'b0,btn,sw}, write led<=wdata[7:0]); 01 display (read/write disp_data); 10 counter (read/write cnt); 11 reserved (read 0, write ignored).
REQ-021 FSM states IDLE, MEM_ISSUE, MEM_WAIT, DONE; cpu_req SHALL be sampled only in IDLE.
REQ-022 On acceptance, cpu_we, cpu_addr, cpu_wdata SHALL be latched; later input changes SHALL NOT affect the access.
REQ-023 I/O access: IDLE->DONE; read data and register write SHALL take effect on the accepting edge; cpu_ready high in the following cycle (latency 1).
REQ-024 RAM access: IDLE->MEM_ISSUE; in MEM_ISSUE mem_en=1, mem_we=latched we, mem_addr=latched addr[MEM_AW+1:2], mem_wdata=latched wdata.
REQ-025 RAM write: MEM_ISSUE->DONE (latency 2); RAM read: MEM_ISSUE->MEM_WAIT, mem_rdata captured into cpu_rdata at end of MEM_WAIT, ->DONE (latency 3).
REQ-026 DONE SHALL assert cpu_ready for exactly one cycle then return to IDLE; back-to-back requests therefore have one idle cycle minimum.
REQ-027 mem_en and mem_we SHALL be 0 in every state other than MEM_ISSUE.
REQ-028 cpu_rdata SHALL hold its last value until the next read completes; writes SHALL NOT modify it.
REQ-029 cnt (32 bits) SHALL increment every cycle, wrapping 32'hFFFFFFFF->0; on a counter write, the written value SHALL win over increment on that edge.
REQ-030 Counter read SHALL return cnt as held before the accepting edge.
REQ-031 sw/btn SHALL be sampled directly at the accepting edge (synchronization is external).

Reset
REQ-032 rst=1 SHALL immediately force: state IDLE, cpu_ready 0, cpu_rdata 0, mem_en 0, mem_we 0, mem_addr 0, mem_wdata 0, led 0, disp_data 0, cnt 0.
REQ-033 rst asserted mid-access SHALL abort it with no cpu_ready pulse and no further RAM or register write.

Verification
REQ-034 Write 0xF0000000 data 0xA5 -> led=8'hA5, cpu_ready one cycle later, mem_en never high.
REQ-035 sw=8'h3C, btn=4'h5, read 0xF0000000 -> cpu_rdata=32'h0000053C with cpu_ready one cycle after accept.
REQ-036 Read 0x00000010 with RAM returning 0xDEADBEEF -> mem_en pulse, mem_addr=4, cpu_rdata=0xDEADBEEF, cpu_ready 3 cycles after accept.
REQ-037 Write counter 0xFFFFFFFE, read two cycles later -> wraps through 0; written value overrides increment on write edge.
REQ-038 Assert rst during MEM_WAIT -> all outputs zero, no cpu_ready, FSM IDLE, next request served normally.
REQ-039 Change cpu_addr/cpu_wdata after acceptance and hold cpu_req high -> access uses latched values; second access accepted only after DONE->IDLE.
